// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection phase sequencer.
//   phase_t   : 3-bit phase encoding, also driven out on the debug phase port
//   *_DEF     : default phase durations (cycles) and the liveness bound
//   max_u     : helper used to size the phase timer
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED     = 3'd0,
    UD_GREEN    = 3'd1,
    UD_YELLOW   = 3'd2,
    TURN_GREEN  = 3'd3,
    TURN_YELLOW = 3'd4,
    PED_WALK    = 3'd5
  } phase_t;

  localparam int unsigned GREEN_MIN_DEF     = 8;
  localparam int unsigned TURN_TIME_DEF     = 8;
  localparam int unsigned PED_TIME_DEF      = 10;
  localparam int unsigned YELLOW_TIME_DEF   = 3;
  localparam int unsigned ALLRED_TIME_DEF   = 2;
  localparam int unsigned SERVICE_BOUND_DEF = 50;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer.
//   clock : posedge clock
//   load  : load `value` this cycle (also used as the reset path by the parent)
//   value : duration to load, in cycles
//   dec   : decrement enable; the count saturates at 0
//   done  : the running phase ends on this clock edge (count is at its last cycle)
module phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over decrement; decrement stops at 0 so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  // A count of 1 means this edge takes it to 0; a saturated 0 stays done
  // so UD green can be held open-ended.
  assign done = (count_q <= WIDTH'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Intersection signal controller: latches pedestrian/turn requests and steps
// through up/down, turn and pedestrian phases with yellow and all-red clearance.
//   clock, reset       : posedge clock, synchronous active-high reset
//   pedestrian_button  : walk request (pulse or level)
//   turn_sensor        : vehicle waiting in the turn lane
//   up/down_green/yellow, turn_green/yellow, pedestrian_green : registered lamps
//   phase              : current phase_t, for debug/coverage
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN     = GREEN_MIN_DEF,
  parameter int unsigned TURN_TIME     = TURN_TIME_DEF,
  parameter int unsigned PED_TIME      = PED_TIME_DEF,
  parameter int unsigned YELLOW_TIME   = YELLOW_TIME_DEF,
  parameter int unsigned ALLRED_TIME   = ALLRED_TIME_DEF,
  parameter int unsigned SERVICE_BOUND = SERVICE_BOUND_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedestrian_button,
  input  logic       turn_sensor,
  output logic       up_green,
  output logic       down_green,
  output logic       up_yellow,
  output logic       down_yellow,
  output logic       turn_green,
  output logic       turn_yellow,
  output logic       pedestrian_green,
  output logic [2:0] phase
);

  localparam int unsigned MAX_DUR = max_u(max_u(max_u(GREEN_MIN, TURN_TIME), max_u(PED_TIME,
                                    YELLOW_TIME)), ALLRED_TIME);
  localparam int unsigned TIMER_W = (MAX_DUR < 1) ? 1 : $clog2(MAX_DUR + 1);

  // Longest request wait: a request just missed lands behind a full UD and turn cycle.
  localparam int unsigned WORST_WAIT = ALLRED_TIME + GREEN_MIN + YELLOW_TIME + ALLRED_TIME +
                                       TURN_TIME + YELLOW_TIME + ALLRED_TIME;
  // Longest UD dark stretch: yellow, turn service, then pedestrian service.
  localparam int unsigned UD_GAP = YELLOW_TIME + ALLRED_TIME + TURN_TIME + YELLOW_TIME +
                                   ALLRED_TIME + PED_TIME + ALLRED_TIME;

  if (WORST_WAIT > SERVICE_BOUND) begin : g_wait_bound_err
    $error("worst-case request wait %0d exceeds SERVICE_BOUND %0d", WORST_WAIT, SERVICE_BOUND);
  end
  if (UD_GAP > SERVICE_BOUND) begin : g_gap_bound_err
    $error("worst-case up/down gap %0d exceeds SERVICE_BOUND %0d", UD_GAP, SERVICE_BOUND);
  end

  phase_t state_q, state_d;
  phase_t next_q, next_d;
  logic   ped_pend_q, ped_pend_d;
  logic   turn_pend_q, turn_pend_d;
  logic   ud_green_q, ud_green_d;
  logic   ud_yellow_q, ud_yellow_d;
  logic   turn_green_q, turn_green_d;
  logic   turn_yellow_q, turn_yellow_d;
  logic   ped_green_q, ped_green_d;
  phase_t phase_q, phase_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;

  function automatic logic [TIMER_W-1:0] phase_duration(input phase_t p);
    case (p)
      UD_GREEN:    phase_duration = TIMER_W'(GREEN_MIN);
      UD_YELLOW:   phase_duration = TIMER_W'(YELLOW_TIME);
      TURN_GREEN:  phase_duration = TIMER_W'(TURN_TIME);
      TURN_YELLOW: phase_duration = TIMER_W'(YELLOW_TIME);
      PED_WALK:    phase_duration = TIMER_W'(PED_TIME);
      default:     phase_duration = TIMER_W'(ALLRED_TIME);
    endcase
  endfunction

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clock (clock),
    .load  (timer_load),
    .value (timer_value),
    .dec   (1'b1),
    .done  (timer_done)
  );

  // State, request latches and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ALL_RED;
      next_q        <= UD_GREEN;
      ped_pend_q    <= 1'b0;
      turn_pend_q   <= 1'b0;
      ud_green_q    <= 1'b0;
      ud_yellow_q   <= 1'b0;
      turn_green_q  <= 1'b0;
      turn_yellow_q <= 1'b0;
      ped_green_q   <= 1'b0;
      phase_q       <= ALL_RED;
    end else begin
      state_q       <= state_d;
      next_q        <= next_d;
      ped_pend_q    <= ped_pend_d;
      turn_pend_q   <= turn_pend_d;
      ud_green_q    <= ud_green_d;
      ud_yellow_q   <= ud_yellow_d;
      turn_green_q  <= turn_green_d;
      turn_yellow_q <= turn_yellow_d;
      ped_green_q   <= ped_green_d;
      phase_q       <= phase_d;
    end
  end

  // Next phase, request latching and timer control.
  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    case (state_q)
      ALL_RED: begin
        if (timer_done) state_d = next_q;
      end
      UD_GREEN: begin
        if (timer_done && (turn_pend_q || ped_pend_q)) state_d = UD_YELLOW;
      end
      UD_YELLOW: begin
        if (timer_done) begin
          state_d = ALL_RED;
          next_d  = turn_pend_q ? TURN_GREEN : PED_WALK;
        end
      end
      TURN_GREEN: begin
        if (timer_done) state_d = TURN_YELLOW;
      end
      TURN_YELLOW: begin
        if (timer_done) begin
          state_d = ALL_RED;
          next_d  = ped_pend_q ? PED_WALK : UD_GREEN;
        end
      end
      PED_WALK: begin
        if (timer_done) begin
          state_d = ALL_RED;
          next_d  = UD_GREEN;
        end
      end
      default: begin
        state_d = ALL_RED;
        next_d  = UD_GREEN;
      end
    endcase

    // A request seen on the cycle its phase is entered counts as served.
    ped_pend_d  = ped_pend_q | (pedestrian_button & (state_q != PED_WALK));
    turn_pend_d = turn_pend_q | (turn_sensor & (state_q != TURN_GREEN));
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) ped_pend_d = 1'b0;
    if ((state_d == TURN_GREEN) && (state_q != TURN_GREEN)) turn_pend_d = 1'b0;

    // Reset reloads the all-red clearance even when it lands mid-phase.
    timer_load  = reset | (state_d != state_q);
    timer_value = reset ? TIMER_W'(ALLRED_TIME) : phase_duration(state_d);
  end

  // Lamp decode from the upcoming phase so the registered lamps track state_q.
  always_comb begin
    ud_green_d    = 1'b0;
    ud_yellow_d   = 1'b0;
    turn_green_d  = 1'b0;
    turn_yellow_d = 1'b0;
    ped_green_d   = 1'b0;
    phase_d       = state_d;
    case (state_d)
      UD_GREEN:    ud_green_d    = 1'b1;
      UD_YELLOW:   ud_yellow_d   = 1'b1;
      TURN_GREEN:  turn_green_d  = 1'b1;
      TURN_YELLOW: turn_yellow_d = 1'b1;
      PED_WALK:    ped_green_d   = 1'b1;
      default:     ;
    endcase
  end

  assign up_green         = ud_green_q;
  assign down_green       = ud_green_q;
  assign up_yellow        = ud_yellow_q;
  assign down_yellow      = ud_yellow_q;
  assign turn_green       = turn_green_q;
  assign turn_yellow      = turn_yellow_q;
  assign pedestrian_green = ped_green_q;
  assign phase            = phase_q;

endmodule
